// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch (IF) and load/store (LS) share one RAM port.
// LS has priority; a starvation counter guarantees IF forward progress.
module mem_arbiter #(
    parameter int unsigned TIMEOUT      = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        Clk,
    input  logic        RESET,

    input  logic        IF_req,
    input  logic [31:0] IF_addr,
    output logic        IF_gnt,
    output logic        IF_done,
    output logic [31:0] IF_rdata,

    input  logic        LS_req,
    input  logic        LS_we,
    input  logic [1:0]  LS_size,
    input  logic [31:0] LS_addr,
    input  logic [31:0] LS_wdata,
    output logic        LS_gnt,
    output logic        LS_done,
    output logic [31:0] LS_rdata,

    output logic        MOV,
    output logic        RAM_rw,
    output logic [1:0]  RAM_size,
    output logic [31:0] RAM_addr,
    output logic [31:0] RAM_wdata,
    input  logic [31:0] RAM_rdata,
    input  logic        MOC,

    output logic        Busy,
    output logic        Timeout,
    output logic        Misalign,
    input  logic        Err_clr
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10,
        FAULT  = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic            owner_ls_q, owner_ls_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            mov_q, mov_d;
    logic            busy_q, busy_d;
    logic            rw_q, rw_d;
    logic [1:0]      size_q, size_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            if_gnt_q, if_gnt_d;
    logic            ls_gnt_q, ls_gnt_d;
    logic            if_done_q, if_done_d;
    logic            ls_done_q, ls_done_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   ls_rdata_q, ls_rdata_d;
    logic            timeout_q, timeout_d;
    logic            misalign_q, misalign_d;

    logic            pick_if;
    logic            fault_mis;
    logic            fault_to;

    // Byte accesses never fault; unused size encoding 11 is passed through unchecked.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        return ((size == SZ_HALF) && lsb[0]) || ((size == SZ_WORD) && (lsb != 2'b00));
    endfunction

    always_comb begin
        state_d    = state_q;
        owner_ls_d = owner_ls_q;
        tcnt_d     = tcnt_q;
        starve_d   = starve_q;
        rw_d       = rw_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        if_gnt_d   = 1'b0;
        ls_gnt_d   = 1'b0;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        fault_mis  = 1'b0;
        fault_to   = 1'b0;
        pick_if    = IF_req && (!LS_req || (starve_q == SW'(STARVE_LIMIT)));

        case (state_q)
            IDLE: begin
                if (IF_req || LS_req) begin
                    tcnt_d = '0;
                    if (pick_if) begin
                        owner_ls_d = 1'b0;
                        if_gnt_d   = 1'b1;
                        rw_d       = 1'b0;
                        size_d     = SZ_WORD;
                        addr_d     = IF_addr;
                        wdata_d    = '0;
                        fault_mis  = is_misaligned(SZ_WORD, IF_addr[1:0]);
                    end else begin
                        owner_ls_d = 1'b1;
                        ls_gnt_d   = 1'b1;
                        rw_d       = LS_we;
                        size_d     = LS_size;
                        addr_d     = LS_addr;
                        wdata_d    = LS_wdata;
                        fault_mis  = is_misaligned(LS_size, LS_addr[1:0]);
                    end
                    // A misaligned request never reaches the RAM; its response word is zero.
                    if (fault_mis) begin
                        state_d = FAULT;
                        if (pick_if) begin
                            if_rdata_d = '0;
                        end else begin
                            ls_rdata_d = '0;
                        end
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (MOC) begin
                    state_d = RESP;
                    if (!rw_q) begin
                        if (owner_ls_q) begin
                            ls_rdata_d = RAM_rdata;
                        end else begin
                            if_rdata_d = RAM_rdata;
                        end
                    end
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                    if (tcnt_q == TW'(TIMEOUT - 1)) begin
                        state_d  = FAULT;
                        fault_to = 1'b1;
                    end
                end
            end
            RESP, FAULT: begin
                state_d = IDLE;
                if (owner_ls_q) begin
                    ls_done_d = 1'b1;
                end else begin
                    if_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Starvation count only accumulates while IF is actually waiting.
        if (!IF_req || if_gnt_d) begin
            starve_d = '0;
        end else if (ls_gnt_d && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + SW'(1);
        end

        timeout_d  = fault_to  | (timeout_q  & ~Err_clr);
        misalign_d = fault_mis | (misalign_q & ~Err_clr);
        mov_d      = (state_d == ACCESS);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            owner_ls_q <= 1'b0;
            tcnt_q     <= '0;
            starve_q   <= '0;
            mov_q      <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_gnt_q   <= 1'b0;
            ls_gnt_q   <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
            timeout_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_ls_q <= owner_ls_d;
            tcnt_q     <= tcnt_d;
            starve_q   <= starve_d;
            mov_q      <= mov_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_gnt_q   <= if_gnt_d;
            ls_gnt_q   <= ls_gnt_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
            timeout_q  <= timeout_d;
            misalign_q <= misalign_d;
        end
    end

    assign IF_gnt    = if_gnt_q;
    assign IF_done   = if_done_q;
    assign IF_rdata  = if_rdata_q;
    assign LS_gnt    = ls_gnt_q;
    assign LS_done   = ls_done_q;
    assign LS_rdata  = ls_rdata_q;
    assign MOV       = mov_q;
    assign RAM_rw    = rw_q;
    assign RAM_size  = size_q;
    assign RAM_addr  = addr_q;
    assign RAM_wdata = wdata_q;
    assign Busy      = busy_q;
    assign Timeout   = timeout_q;
    assign Misalign  = misalign_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model predicts winner, latency,
// MOV duration, response data and sticky flags for every access.
module tb_mem_arbiter;

    localparam int unsigned TIMEOUT      = 16;
    localparam int unsigned STARVE_LIMIT = 4;

    logic        Clk;
    logic        RESET;
    logic        IF_req;
    logic [31:0] IF_addr;
    logic        IF_gnt, IF_done;
    logic [31:0] IF_rdata;
    logic        LS_req, LS_we;
    logic [1:0]  LS_size;
    logic [31:0] LS_addr, LS_wdata;
    logic        LS_gnt, LS_done;
    logic [31:0] LS_rdata;
    logic        MOV, RAM_rw;
    logic [1:0]  RAM_size;
    logic [31:0] RAM_addr, RAM_wdata, RAM_rdata;
    logic        MOC;
    logic        Busy, Timeout, Misalign, Err_clr;

    mem_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .Clk(Clk), .RESET(RESET),
        .IF_req(IF_req), .IF_addr(IF_addr), .IF_gnt(IF_gnt), .IF_done(IF_done), .IF_rdata(IF_rdata),
        .LS_req(LS_req), .LS_we(LS_we), .LS_size(LS_size), .LS_addr(LS_addr), .LS_wdata(LS_wdata),
        .LS_gnt(LS_gnt), .LS_done(LS_done), .LS_rdata(LS_rdata),
        .MOV(MOV), .RAM_rw(RAM_rw), .RAM_size(RAM_size), .RAM_addr(RAM_addr), .RAM_wdata(RAM_wdata),
        .RAM_rdata(RAM_rdata), .MOC(MOC),
        .Busy(Busy), .Timeout(Timeout), .Misalign(Misalign), .Err_clr(Err_clr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          m_starve;
    logic [31:0] m_if_rd, m_ls_rd;
    logic        m_to, m_mis;
    logic        obs_if_gnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic misaligned(input logic [1:0] size, input logic [31:0] addr);
        int unsigned nbytes;
        nbytes = 32'd1 << size;
        return (addr % nbytes) != 0;
    endfunction

    task automatic model_reset();
        m_starve = 0;
        m_if_rd  = '0;
        m_ls_rd  = '0;
        m_to     = 1'b0;
        m_mis    = 1'b0;
    endtask

    // Called just after a negedge with the DUT idle. w = MOC wait cycles (>= TIMEOUT means never).
    task automatic do_txn(input logic if_on, input logic ls_on, input logic ls_we,
                          input logic [1:0] ls_size, input logic [31:0] if_a, input logic [31:0] ls_a,
                          input logic [31:0] wd, input int w, input logic [31:0] rd,
                          input logic clr, input logic drop);
        logic        win_if, mis, to, exp_rw;
        logic [1:0]  exp_size;
        logic [31:0] exp_addr;
        int          movcnt, done_k, exp_done, exp_mov, bad_busy, bad_gnt;

        IF_req    = if_on;
        IF_addr   = if_a;
        LS_req    = ls_on;
        LS_we     = ls_we;
        LS_size   = ls_size;
        LS_addr   = ls_a;
        LS_wdata  = wd;
        Err_clr   = clr;
        MOC       = 1'($urandom);
        RAM_rdata = $urandom;

        win_if   = if_on && (!ls_on || (m_starve == int'(STARVE_LIMIT)));
        mis      = win_if ? misaligned(2'b10, if_a) : misaligned(ls_size, ls_a);
        to       = !mis && (w >= int'(TIMEOUT));
        exp_rw   = win_if ? 1'b0 : ls_we;
        exp_size = win_if ? 2'b10 : ls_size;
        exp_addr = win_if ? if_a : ls_a;
        if (!if_on || win_if) m_starve = 0;
        else if (m_starve < int'(STARVE_LIMIT)) m_starve++;
        if (clr) begin
            m_to  = 1'b0;
            m_mis = 1'b0;
        end
        if (mis) m_mis = 1'b1;

        @(negedge Clk);
        Err_clr    = 1'b0;
        obs_if_gnt = IF_gnt;
        check("if_gnt", 32'(IF_gnt), 32'(win_if));
        check("ls_gnt", 32'(LS_gnt), 32'(!win_if));
        check("done_at_gnt", 32'(IF_done | LS_done), 32'(0));
        check("busy_at_gnt", 32'(Busy), 32'(1));
        check("mov_at_gnt", 32'(MOV), 32'(!mis));
        check("misalign_at_gnt", 32'(Misalign), 32'(m_mis));
        check("timeout_at_gnt", 32'(Timeout), 32'(m_to));
        if (!mis) begin
            check("ram_rw", 32'(RAM_rw), 32'(exp_rw));
            check("ram_size", 32'(RAM_size), 32'(exp_size));
            check("ram_addr", RAM_addr, exp_addr);
            if (!win_if) check("ram_wdata", RAM_wdata, wd);
        end
        if (drop) begin
            if (win_if) IF_req = 1'b0;
            else        LS_req = 1'b0;
        end

        movcnt   = int'(MOV);
        done_k   = -1;
        bad_busy = 0;
        bad_gnt  = 0;
        for (int k = 1; k <= 40; k++) begin
            if (!mis && (k <= w)) begin
                MOC       = 1'b0;
                RAM_rdata = $urandom;
            end else if (!mis && !to && (k == w + 1)) begin
                MOC       = 1'b1;
                RAM_rdata = rd;
            end else begin
                MOC       = 1'($urandom);
                RAM_rdata = $urandom;
            end
            @(negedge Clk);
            movcnt += int'(MOV);
            if (IF_gnt || LS_gnt) bad_gnt++;
            if (IF_done || LS_done) begin
                done_k = k;
                break;
            end
            if (!Busy) bad_busy++;
        end
        MOC = 1'b0;

        exp_done = mis ? 1 : (to ? int'(TIMEOUT) + 1 : w + 2);
        exp_mov  = mis ? 0 : (to ? int'(TIMEOUT) : w + 1);
        if (to) m_to = 1'b1;
        if (mis) begin
            if (win_if) m_if_rd = '0;
            else        m_ls_rd = '0;
        end else if (!to && !exp_rw) begin
            if (win_if) m_if_rd = rd;
            else        m_ls_rd = rd;
        end

        check("done_latency", 32'(done_k), 32'(exp_done));
        check("if_done", 32'(IF_done), 32'(win_if));
        check("ls_done", 32'(LS_done), 32'(!win_if));
        check("mov_cycles", 32'(movcnt), 32'(exp_mov));
        check("if_rdata", IF_rdata, m_if_rd);
        check("ls_rdata", LS_rdata, m_ls_rd);
        check("timeout_flag", 32'(Timeout), 32'(m_to));
        check("misalign_flag", 32'(Misalign), 32'(m_mis));
        check("busy_at_done", 32'(Busy), 32'(0));
        check("busy_in_flight", 32'(bad_busy), 32'(0));
        check("extra_gnt", 32'(bad_gnt), 32'(0));
    endtask

    initial begin
        int          w;
        logic        if_on, ls_on, drop, clr;
        logic [31:0] if_a, ls_a;

        RESET = 1'b0;  IF_req = 1'b0; IF_addr = '0; LS_req = 1'b0; LS_we = 1'b0;
        LS_size = '0;  LS_addr = '0;  LS_wdata = '0; RAM_rdata = '0; MOC = 1'b0; Err_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge Clk);
        check("rst_mov", 32'(MOV), 32'(0));
        check("rst_busy", 32'(Busy), 32'(0));
        check("rst_gnt", 32'({IF_gnt, LS_gnt}), 32'(0));
        check("rst_done", 32'({IF_done, LS_done}), 32'(0));
        check("rst_if_rdata", IF_rdata, 32'h0);
        check("rst_ls_rdata", LS_rdata, 32'h0);
        check("rst_flags", 32'({Timeout, Misalign}), 32'(0));
        check("rst_ram_addr", RAM_addr, 32'h0);
        RESET = 1'b1;
        @(negedge Clk);
        check("idle_no_req", 32'(Busy), 32'(0));

        // Basic fetch with one MOC wait cycle
        do_txn(1'b1, 1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 32'h0, 1, 32'hDEADBEEF, 1'b0, 1'b0);

        // Both requesters held: four LS grants then one IF grant, repeating
        for (int i = 0; i < 10; i++) begin
            do_txn(1'b1, 1'b1, 1'b0, 2'b10, 32'h400 + 32'(4 * i), 32'h800 + 32'(4 * i), 32'h0,
                   $urandom_range(0, 2), $urandom, 1'b0, 1'b0);
            check("starve_pattern", 32'(obs_if_gnt), 32'((i % 5) == 4));
        end

        // Misaligned word store, then clear the sticky flag
        do_txn(1'b0, 1'b1, 1'b1, 2'b10, 32'h0, 32'h102, 32'h1234, 0, 32'h0, 1'b0, 1'b0);
        IF_req = 1'b0; LS_req = 1'b0; Err_clr = 1'b1;
        @(negedge Clk);
        Err_clr = 1'b0;
        m_mis = 1'b0; m_to = 1'b0; m_starve = 0;
        check("misalign_cleared", 32'(Misalign), 32'(0));

        // Load that never completes
        do_txn(1'b0, 1'b1, 1'b0, 2'b10, 32'h0, 32'h40, 32'h0, 100, 32'h0, 1'b0, 1'b0);

        // Byte store to an odd address
        do_txn(1'b0, 1'b1, 1'b1, 2'b00, 32'h0, 32'h203, 32'hAB, 2, $urandom, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            if_on = 1'($urandom);
            ls_on = 1'($urandom);
            if (!if_on && !ls_on) ls_on = 1'b1;
            if_a  = ($urandom & 32'hFFFF_FFFC) | ((($urandom % 5) == 0) ? ($urandom % 4) : 32'h0);
            ls_a  = ($urandom & 32'hFFFF_FFFC) | ((($urandom % 3) == 0) ? ($urandom % 4) : 32'h0);
            w     = (($urandom % 8) == 0) ? int'(TIMEOUT) + int'($urandom % 4) : int'($urandom % 6);
            clr   = (($urandom % 6) == 0);
            drop  = (($urandom % 4) == 0);
            do_txn(if_on, ls_on, 1'($urandom), 2'($urandom_range(0, 2)), if_a, ls_a, $urandom,
                   w, $urandom, clr, drop);
        end

        // Asynchronous reset in the middle of an access
        IF_req = 1'b0; LS_req = 1'b1; LS_we = 1'b0; LS_size = 2'b10; LS_addr = 32'h300;
        @(negedge Clk);
        check("pre_rst_gnt", 32'(LS_gnt), 32'(1));
        check("pre_rst_mov", 32'(MOV), 32'(1));
        #2 RESET = 1'b0;
        #1;
        check("async_rst_mov", 32'(MOV), 32'(0));
        check("async_rst_busy", 32'(Busy), 32'(0));
        check("async_rst_gnt", 32'(LS_gnt), 32'(0));
        check("async_rst_ls_rdata", LS_rdata, 32'h0);
        check("async_rst_if_rdata", IF_rdata, 32'h0);
        check("async_rst_flags", 32'({Timeout, Misalign}), 32'(0));
        model_reset();
        @(negedge Clk);
        RESET = 1'b1;
        do_txn(1'b0, 1'b1, 1'b0, 2'b10, 32'h0, 32'h300, 32'h0, 0, 32'hCAFE_F00D, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
